imem_loader: RTL

//   Write-side counterpart of the 1024x32 instruction memory: receives a byte stream
//   (valid/ready), packs 4 bytes MSB-first into 32-bit LEGv8 instructions, and drives
//   the memory write port at consecutive word addresses starting at 0.

---
 rtl/imem_loader_pkg.sv | 12 +
 rtl/imem_loader_byte_packer.sv | 25 ++
 rtl/imem_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared sizes and FSM encodings for the instruction-memory loader.
package imem_loader_pkg;
  localparam int IMEM_ADDR_W    = 10;
  localparam int IMEM_WORDS     = 1 << IMEM_ADDR_W;
  localparam int BYTES_PER_WORD = 4;
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RECV   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_CKSUM  = 3'd4;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts bytes in MSB-first and flags the 4th byte of each word.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        take_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  assign word_o       = sr_q;
  assign word_valid_o = take_i && cnt_q == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk)
    if (reset || clear_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (take_i) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {sr_q[23:0], byte_i};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit words and writes them to instruction memory.
// Define IMEM_LOADER_CKSUM_EN to require a trailing XOR checksum byte after the image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] S_END = S_CKSUM;
`else
  localparam logic [2:0] S_END = S_FINISH;
`endif
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, num_q, num_d;
  logic              err_q, err_d;
  logic              take, load, last, word_valid;
  assign byte_ready = state_q == S_RECV || state_q == S_CKSUM;
  assign wr_en      = state_q == S_WRITE;
  assign done       = state_q == S_FINISH;
  assign cpu_hold   = state_q == S_RECV || state_q == S_WRITE || state_q == S_CKSUM;
  assign wr_addr    = addr_q;
  assign error      = err_q;
  assign take       = byte_valid && byte_ready;
  assign load       = state_q == S_IDLE && start && num_words <= DEPTH;
  assign last       = cnt_q + (ADDR_W + 1)'(1) == num_q;
  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (load),
    .take_i       (take && state_q == S_RECV),
    .byte_i       (byte_in),
    .word_o       (wr_data),
    .word_valid_o (word_valid)
  );
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  assign sum_d = load ? '0 : (take && state_q == S_RECV) ? sum_q ^ byte_in : sum_q;
  always_ff @(posedge clk) sum_q <= reset ? '0 : sum_d;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:
        if (start) begin
          if (!load) err_d = 1'b1;
          else begin
            err_d   = 1'b0;
            num_d   = num_words;
            cnt_d   = '0;
            addr_d  = '0;
            state_d = num_words == '0 ? S_END : S_RECV;
          end
        end
      S_RECV: if (word_valid) state_d = S_WRITE;
      S_WRITE: begin
        cnt_d = cnt_q + (ADDR_W + 1)'(1);
        // the address stops on the final word so a full-depth load never wraps
        if (last) state_d = S_END;
        else begin
          state_d = S_RECV;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM:
        if (take) begin
          err_d   = byte_in != sum_q;
          state_d = S_FINISH;
        end
`endif
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      err_q   <= err_d;
    end
endmodule
